ahb_master: RTL and testbench
=============================

Name: ahb_master

Overview:
AHB-Lite initiator that turns single-command requests from a local client into AHB transfers (SINGLE or INCR4, word size).
- Drives the address/control bus into the shared address decoder and slaves.
- Samples hready/hresp/hrdata.
- Returns read data, and reports completion/error per command.
- Counterpart of the decoder/default-slave logic; the default slave's two-cycle ERROR response is handled here.

Parameters:
AW, 32, address width
DW, 32, data width (hsize fixed to log2(DW/8))

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_burst  in  1  0=SINGLE, 1=INCR4
cmd_addr  in  AW  start address, DW/8-aligned
wd_valid  in  1  write beat available
wd_data  in  DW  write beat data
wd_ready  out  1  write beat consumed this cycle
rd_valid  out  1  read beat valid (one-cycle pulse)
rd_data  out  DW  read beat data
done  out  1  command complete (one-cycle pulse)
err  out  1  valid with done; 1 = ERROR response received
haddr  out  AW  AHB address
htrans  out  2  AHB transfer type
hwrite  out  1  AHB direction
hsize  out  3  AHB size
hburst  out  3  AHB burst
hwdata  out  DW  AHB write data
hrdata  in  DW  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB response (OKAY/ERROR)

Behaviour:
- Reset values (async, rst high):
  - htrans=IDLE, haddr=0, hwrite=0, hburst=SINGLE, hsize=log2(DW/8), hwdata=0.
  - rd_valid=0, rd_data=0, done=0, err=0, wd_ready=0.
  - State IDLE, beat counters 0.
- cmd_ready = (state==IDLE) & !rst. Command fields are latched on acceptance.
- States and transitions:
  - IDLE: on accept go to ADDR.
  - ADDR: drives the NONSEQ for beat 0. For a write, the NONSEQ is driven only while wd_valid=1; otherwise htrans=IDLE and the block stays in ADDR.
  - BURST: SEQ beats 1..3 (INCR4 only).
  - LAST: data phase of the final beat, htrans=IDLE.
  - ERR: second cycle of an ERROR response.
- Address phase completes on a cycle with htrans∈{NONSEQ,SEQ} and hready=1.
  - Address/control are held unchanged while hready=0.
  - The next beat's address = previous + DW/8.
- Writes:
  - wd_ready=1 exactly in the cycle a write address phase completes.
  - wd_data is registered into hwdata, valid for the following data phase and held while hready=0.
- Write data underrun mid-burst (wd_valid=0 when the next SEQ beat is due): drive htrans=BUSY with the next beat's address. Resume SEQ when wd_valid=1. BUSY never occurs on beat 0 or after beat 3.
- Reads: data phase completes on hready=1 & hresp=OKAY → rd_valid=1, rd_data=hrdata, registered, 1-cycle latency.
- Pipelining:
  - Beat n+1's address phase overlaps beat n's data phase.
  - INCR4 with no wait states takes 5 bus cycles NONSEQ→last data phase.
  - done pulses the cycle after the last data phase completes.
- 1 KB boundary:
  - If INCR4 and cmd_addr[9:0] > 0x3F0, issue hburst=INCR (3'b001) instead of INCR4.
  - The first beat at a new 1 KB page is NONSEQ.
- ERROR (hresp=ERROR with hready=0, cycle 1):
  - Next cycle drive htrans=IDLE; the in-flight address phase is cancelled; remaining beats are dropped; go to ERR.
  - No rd_valid for the errored beat.
  - On cycle 2 (hready=1), done=1 and err=1 the following cycle, then IDLE.
  - No further wd_ready for that command. Unconsumed write beats stay the client's responsibility.
- rst asserted mid-command: immediate return to reset values. No done pulse. The bus shows IDLE.
- cmd_valid while busy: ignored (cmd_ready=0).

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t {IDLE,BUSY,NONSEQ,SEQ}
  - hresp_t {OKAY,ERROR}
  - hburst constants SINGLE=3'b000, INCR=3'b001, INCR4=3'b011
  - HSIZE_WORD=3'b010
- Master FSM state enum is local to ahb_master.
- One natural sub-module: ahb_master_addr_gen (beat counter, address increment, 1 KB page-cross detect, NONSEQ/SEQ select).

Test Plan:
- Single read 0x0000_0100, hready=1, hrdata=0xDEADBEEF → NONSEQ/SINGLE one cycle, rd_valid with 0xDEADBEEF one cycle after data phase, done=1 err=0.
- INCR4 write 0x0000_0200, data 1..4, zero-wait slave → haddr 0x200,0x204,0x208,0x20C NONSEQ,SEQ,SEQ,SEQ on consecutive cycles; hwdata 1..4 lagging by one cycle; done err=0.
- Same INCR4 write with wd_valid low for 2 cycles before beat 2 → htrans=BUSY for 2 cycles at haddr 0x208, then SEQ; all 4 beats written.
- INCR4 read 0x0000_0000 with hready=0 for 3 cycles on beat 1 → address/control held 3 cycles, four rd_valid pulses in order.
- Single write to 0x0000_1000 (unmapped, default slave) → hresp=ERROR two-cycle, htrans=IDLE in cycle 2, done=1 err=1, no retry.
- INCR4 read at 0x0000_03F8 → hburst=INCR, beat 2 at 0x400 issued NONSEQ. Separately, rst pulsed during beat 1 of any burst → outputs at reset values, no done pulse.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the initiator, the decoder side and the bench.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_t;

    localparam logic [2:0] SINGLE     = 3'b000;
    localparam logic [2:0] INCR       = 3'b001;
    localparam logic [2:0] INCR4      = 3'b011;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Last page offset from which four words still fit below the 1 KB boundary.
    localparam logic [9:0] INCR4_MAX_OFFSET = 10'h3F0;

    // A burst that would cross a 1 KB page is announced as INCR, not INCR4.
    function automatic logic [2:0] burst_code(input logic incr4, input logic [9:0] page_offset);
        if (!incr4) begin
            return SINGLE;
        end
        if (page_offset > INCR4_MAX_OFFSET) begin
            return INCR;
        end
        return INCR4;
    endfunction

endpackage

// File: rtl/ahb_master_if.sv
// AHB-Lite address/control/data bus between one initiator and the decoder/slaves.
interface ahb_master_if
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic [AW-1:0] haddr;
    htrans_t       htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    hresp_t        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_master_addr_gen.sv
// Beat counter and address sequencer: holds haddr, steps it per accepted beat and
// flags the first beat of a new 1 KB page so it is issued as NONSEQ.
module ahb_master_addr_gen #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic          incr4,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] addr,
    output logic          last_beat,
    output logic          seq_ok
);

    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    logic [1:0] beat;
    logic       burst_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            beat    <= '0;
            burst_q <= 1'b0;
        end else if (load) begin
            addr    <= start_addr;
            beat    <= '0;
            burst_q <= incr4;
        end else if (advance) begin
            addr <= addr + STEP;
            beat <= beat + 2'd1;
        end
    end

    assign last_beat = !burst_q || (beat == 2'd3);
    assign seq_ok    = (beat != 2'd0) && (addr[9:0] != 10'd0);

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns single commands into SINGLE or INCR4 word transfers,
// returns read beats and reports completion/error per command.
module ahb_master
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic          cmd_burst,
    input  logic [AW-1:0] cmd_addr,
    input  logic          wd_valid,
    input  logic [DW-1:0] wd_data,
    output logic          wd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    ahb_master_if.master  bus
);

    localparam logic [2:0] HSIZE = 3'($clog2(DW / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    state_t        state;
    state_t        next_state;
    htrans_t       htrans_c;
    logic          write_q;
    logic [2:0]    hburst_q;
    logic [DW-1:0] hwdata_q;
    logic          dp_valid;
    logic          hold;
    logic          accept;
    logic          addr_done;
    logic          err_hit;
    logic          wd_ok;
    logic          rd_fire;
    logic          last_beat;
    logic          seq_ok;
    logic          done_d;
    logic          err_d;
    logic [AW-1:0] addr;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign addr_done = ((htrans_c == NONSEQ) || (htrans_c == SEQ)) && bus.hready;
    assign wd_ready  = addr_done && write_q;
    assign err_hit   = dp_valid && !bus.hready && (bus.hresp == ERROR);
    assign rd_fire   = dp_valid && bus.hready && (bus.hresp == OKAY) && !write_q;

    // An address phase already on the bus is held even if the write beat vanishes.
    assign wd_ok = !write_q || wd_valid || hold;

    ahb_master_addr_gen #(
        .AW (AW),
        .DW (DW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .advance    (addr_done),
        .incr4      (cmd_burst),
        .start_addr (cmd_addr),
        .addr       (addr),
        .last_beat  (last_beat),
        .seq_ok     (seq_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        htrans_c   = IDLE;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (wd_ok) begin
                    htrans_c = NONSEQ;
                    if (bus.hready) begin
                        next_state = last_beat ? S_LAST : S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (!wd_ok) begin
                    htrans_c = BUSY;
                end else if (seq_ok) begin
                    htrans_c = SEQ;
                end else begin
                    htrans_c = NONSEQ;
                end
                // First ERROR cycle: the pending beat is abandoned next cycle.
                if (err_hit) begin
                    next_state = S_ERR;
                end else if (wd_ok && bus.hready) begin
                    next_state = last_beat ? S_LAST : S_BURST;
                end
            end
            S_LAST: begin
                if (err_hit) begin
                    next_state = S_ERR;
                end else if (bus.hready) begin
                    next_state = S_IDLE;
                    done_d     = 1'b1;
                end
            end
            S_ERR: begin
                if (bus.hready) begin
                    next_state = S_IDLE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q  <= 1'b0;
            hburst_q <= SINGLE;
            hwdata_q <= '0;
            dp_valid <= 1'b0;
            hold     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= cmd_write;
                hburst_q <= burst_code(cmd_burst, cmd_addr[9:0]);
            end
            if (wd_ready) begin
                hwdata_q <= wd_data;
            end
            if (addr_done) begin
                dp_valid <= 1'b1;
            end else if (bus.hready || err_hit) begin
                dp_valid <= 1'b0;
            end
            hold     <= ((htrans_c == NONSEQ) || (htrans_c == SEQ)) && !bus.hready
                        && (next_state != S_ERR);
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= bus.hrdata;
            end
            done <= done_d;
            err  <= err_d;
        end
    end

    assign bus.haddr  = addr;
    assign bus.htrans = htrans_c;
    assign bus.hwrite = write_q;
    assign bus.hsize  = HSIZE;
    assign bus.hburst = hburst_q;
    assign bus.hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: the bench plays client and slave cycle by cycle
// and compares the bus and client outputs against hand-computed values.
module tb_ahb_master;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic          cmd_burst;
    logic [AW-1:0] cmd_addr;
    logic          wd_valid;
    logic [DW-1:0] wd_data;
    logic          wd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    ahb_master_if #(.AW(AW), .DW(DW)) bus ();

    ahb_master #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_burst (cmd_burst),
        .cmd_addr  (cmd_addr),
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command for one cycle; returns 1 ns after the accepting edge.
    task automatic issue(input string tag, input logic w, input logic b, input logic [AW-1:0] a);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_burst = b;
        cmd_addr  = a;
        @(negedge clk);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_step(input string tag, input logic wv, input logic [DW-1:0] wdat,
                              input htrans_t et, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ehw, input logic ewr, input logic [1:0] ede);
        wd_valid = wv;
        wd_data  = wdat;
        @(negedge clk);
        check({tag, ".htrans"}, 64'(bus.htrans), 64'(et));
        if (et != IDLE) begin
            check({tag, ".haddr"}, 64'(bus.haddr), 64'(ea));
        end
        check({tag, ".hwdata"}, 64'(bus.hwdata), 64'(ehw));
        check({tag, ".wd_ready"}, 64'(wd_ready), 64'(ewr));
        check({tag, ".done_err"}, 64'({done, err}), 64'(ede));
        @(posedge clk);
        #1;
    endtask

    task automatic read_step(input string tag, input logic hr, input logic [DW-1:0] hrd,
                             input htrans_t et, input logic [AW-1:0] ea,
                             input logic erv, input logic [DW-1:0] erd, input logic [1:0] ede);
        bus.hready = hr;
        bus.hrdata = hrd;
        @(negedge clk);
        check({tag, ".htrans"}, 64'(bus.htrans), 64'(et));
        if (et != IDLE) begin
            check({tag, ".haddr"}, 64'(bus.haddr), 64'(ea));
        end
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(erv));
        if (erv) begin
            check({tag, ".rd_data"}, 64'(rd_data), 64'(erd));
        end
        check({tag, ".done_err"}, 64'({done, err}), 64'(ede));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".htrans"}, 64'(bus.htrans), 64'(IDLE));
        check({tag, ".haddr"}, 64'(bus.haddr), 64'(0));
        check({tag, ".hwrite"}, 64'(bus.hwrite), 64'(0));
        check({tag, ".hburst"}, 64'(bus.hburst), 64'(SINGLE));
        check({tag, ".hsize"}, 64'(bus.hsize), 64'(HSIZE_WORD));
        check({tag, ".hwdata"}, 64'(bus.hwdata), 64'(0));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(0));
        check({tag, ".rd_data"}, 64'(rd_data), 64'(0));
        check({tag, ".done_err"}, 64'({done, err}), 64'(0));
        check({tag, ".wd_ready"}, 64'(wd_ready), 64'(0));
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_burst  = 1'b0;
        cmd_addr   = '0;
        wd_valid   = 1'b0;
        wd_data    = '0;
        bus.hready = 1'b1;
        bus.hresp  = OKAY;
        bus.hrdata = '0;

        @(posedge clk);
        #1;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset.cmd_ready", 64'(cmd_ready), 64'(1));

        // Single read, zero wait; a second request while busy must be ignored.
        issue("rd1", 1'b0, 1'b0, 32'h0000_0100);
        check("rd1.hburst", 64'(bus.hburst), 64'(SINGLE));
        check("rd1.hwrite", 64'(bus.hwrite), 64'(0));
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0999;
        check("rd1.busy_ready", 64'(cmd_ready), 64'(0));
        read_step("rd1_c1", 1'b1, 32'h0, NONSEQ, 32'h100, 1'b0, 32'h0, 2'b00);
        check("rd1.busy_ready2", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b0;
        read_step("rd1_c2", 1'b1, 32'hDEAD_BEEF, IDLE, 32'h0, 1'b0, 32'h0, 2'b00);
        read_step("rd1_c3", 1'b1, 32'h0, IDLE, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'b10);
        read_step("rd1_c4", 1'b1, 32'h0, IDLE, 32'h0, 1'b0, 32'h0, 2'b00);

        // INCR4 write, zero wait.
        wd_valid = 1'b1;
        wd_data  = 32'd1;
        issue("w4", 1'b1, 1'b1, 32'h0000_0200);
        check("w4.hburst", 64'(bus.hburst), 64'(INCR4));
        check("w4.hwrite", 64'(bus.hwrite), 64'(1));
        write_step("w4_c1", 1'b1, 32'd1, NONSEQ, 32'h200, 32'd0, 1'b1, 2'b00);
        write_step("w4_c2", 1'b1, 32'd2, SEQ,    32'h204, 32'd1, 1'b1, 2'b00);
        write_step("w4_c3", 1'b1, 32'd3, SEQ,    32'h208, 32'd2, 1'b1, 2'b00);
        write_step("w4_c4", 1'b1, 32'd4, SEQ,    32'h20C, 32'd3, 1'b1, 2'b00);
        write_step("w4_c5", 1'b0, 32'd0, IDLE,   32'h0,   32'd4, 1'b0, 2'b00);
        write_step("w4_c6", 1'b0, 32'd0, IDLE,   32'h0,   32'd4, 1'b0, 2'b10);

        // INCR4 write with a two-cycle underrun before beat 2.
        wd_valid = 1'b1;
        wd_data  = 32'd1;
        issue("wb", 1'b1, 1'b1, 32'h0000_0200);
        write_step("wb_c1", 1'b1, 32'd1, NONSEQ, 32'h200, 32'd4, 1'b1, 2'b00);
        write_step("wb_c2", 1'b1, 32'd2, SEQ,    32'h204, 32'd1, 1'b1, 2'b00);
        write_step("wb_c3", 1'b0, 32'd3, BUSY,   32'h208, 32'd2, 1'b0, 2'b00);
        write_step("wb_c4", 1'b0, 32'd3, BUSY,   32'h208, 32'd2, 1'b0, 2'b00);
        write_step("wb_c5", 1'b1, 32'd3, SEQ,    32'h208, 32'd2, 1'b1, 2'b00);
        write_step("wb_c6", 1'b1, 32'd4, SEQ,    32'h20C, 32'd3, 1'b1, 2'b00);
        write_step("wb_c7", 1'b0, 32'd0, IDLE,   32'h0,   32'd4, 1'b0, 2'b00);
        write_step("wb_c8", 1'b0, 32'd0, IDLE,   32'h0,   32'd4, 1'b0, 2'b10);

        // INCR4 read with three wait states while beat 1 is on the address bus.
        issue("rw", 1'b0, 1'b1, 32'h0000_0000);
        read_step("rw_c1", 1'b1, 32'h0,     NONSEQ, 32'h0, 1'b0, 32'h0,   2'b00);
        read_step("rw_c2", 1'b0, 32'hBAD0,  SEQ,    32'h4, 1'b0, 32'h0,   2'b00);
        read_step("rw_c3", 1'b0, 32'hBAD1,  SEQ,    32'h4, 1'b0, 32'h0,   2'b00);
        check("rw.hburst_held", 64'(bus.hburst), 64'(INCR4));
        check("rw.hwrite_held", 64'(bus.hwrite), 64'(0));
        read_step("rw_c4", 1'b0, 32'hBAD2,  SEQ,    32'h4, 1'b0, 32'h0,   2'b00);
        read_step("rw_c5", 1'b1, 32'hA000,  SEQ,    32'h4, 1'b0, 32'h0,   2'b00);
        read_step("rw_c6", 1'b1, 32'hA001,  SEQ,    32'h8, 1'b1, 32'hA000, 2'b00);
        read_step("rw_c7", 1'b1, 32'hA002,  SEQ,    32'hC, 1'b1, 32'hA001, 2'b00);
        read_step("rw_c8", 1'b1, 32'hA003,  IDLE,   32'h0, 1'b1, 32'hA002, 2'b00);
        read_step("rw_c9", 1'b1, 32'h0,     IDLE,   32'h0, 1'b1, 32'hA003, 2'b10);
        read_step("rw_c10", 1'b1, 32'h0,    IDLE,   32'h0, 1'b0, 32'h0,   2'b00);

        // Single write to an unmapped address: two-cycle ERROR, no retry.
        wd_valid = 1'b1;
        wd_data  = 32'h55;
        issue("we", 1'b1, 1'b0, 32'h0000_1000);
        write_step("we_c1", 1'b1, 32'h55, NONSEQ, 32'h1000, 32'd4, 1'b1, 2'b00);
        bus.hready = 1'b0;
        bus.hresp  = ERROR;
        write_step("we_c2", 1'b0, 32'h0, IDLE, 32'h0, 32'h55, 1'b0, 2'b00);
        bus.hready = 1'b1;
        write_step("we_c3", 1'b0, 32'h0, IDLE, 32'h0, 32'h55, 1'b0, 2'b00);
        bus.hresp = OKAY;
        write_step("we_c4", 1'b0, 32'h0, IDLE, 32'h0, 32'h55, 1'b0, 2'b11);
        write_step("we_c5", 1'b0, 32'h0, IDLE, 32'h0, 32'h55, 1'b0, 2'b00);
        check("we.cmd_ready", 64'(cmd_ready), 64'(1));

        // INCR4 read erroring on beat 1: beat 2 address cancelled, rest dropped.
        issue("re", 1'b0, 1'b1, 32'h0000_0300);
        read_step("re_c1", 1'b1, 32'h0,    NONSEQ, 32'h300, 1'b0, 32'h0,    2'b00);
        read_step("re_c2", 1'b1, 32'hA5A5, SEQ,    32'h304, 1'b0, 32'h0,    2'b00);
        bus.hresp = ERROR;
        read_step("re_c3", 1'b0, 32'hBAD3, SEQ,    32'h308, 1'b1, 32'hA5A5, 2'b00);
        read_step("re_c4", 1'b1, 32'hBAD4, IDLE,   32'h0,   1'b0, 32'h0,    2'b00);
        bus.hresp = OKAY;
        read_step("re_c5", 1'b1, 32'h0,    IDLE,   32'h0,   1'b0, 32'h0,    2'b11);
        read_step("re_c6", 1'b1, 32'h0,    IDLE,   32'h0,   1'b0, 32'h0,    2'b00);

        // INCR4 read across the 1 KB boundary: INCR, and NONSEQ at 0x400.
        issue("rp", 1'b0, 1'b1, 32'h0000_03F8);
        check("rp.hburst", 64'(bus.hburst), 64'(INCR));
        read_step("rp_c1", 1'b1, 32'h0,    NONSEQ, 32'h3F8, 1'b0, 32'h0,    2'b00);
        read_step("rp_c2", 1'b1, 32'hB000, SEQ,    32'h3FC, 1'b0, 32'h0,    2'b00);
        read_step("rp_c3", 1'b1, 32'hB001, NONSEQ, 32'h400, 1'b1, 32'hB000, 2'b00);
        read_step("rp_c4", 1'b1, 32'hB002, SEQ,    32'h404, 1'b1, 32'hB001, 2'b00);
        read_step("rp_c5", 1'b1, 32'hB003, IDLE,   32'h0,   1'b1, 32'hB002, 2'b00);
        read_step("rp_c6", 1'b1, 32'h0,    IDLE,   32'h0,   1'b1, 32'hB003, 2'b10);

        // Reset pulsed while beat 1 of a burst is on the bus.
        issue("rr", 1'b0, 1'b1, 32'h0000_0500);
        read_step("rr_c1", 1'b1, 32'hC000, NONSEQ, 32'h500, 1'b0, 32'h0, 2'b00);
        check("rr.pre_htrans", 64'(bus.htrans), 64'(SEQ));
        rst = 1'b1;
        #1;
        check_reset_values("rr_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rr.cmd_ready", 64'(cmd_ready), 64'(1));
        read_step("rr_c3", 1'b1, 32'h0, IDLE, 32'h0, 1'b0, 32'h0, 2'b00);
        read_step("rr_c4", 1'b1, 32'h0, IDLE, 32'h0, 1'b0, 32'h0, 2'b00);
        read_step("rr_c5", 1'b1, 32'h0, IDLE, 32'h0, 1'b0, 32'h0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
